// File: rtl/data_distributor.sv
`default_nettype none
// ============================================================================
// data_distributor : registered 1-to-4 distributor with valid/ready channels
// Optional feature: define DISTRIB_CNT_EN to add the CNT accepted-word counter
// Revision: 1.0
// ============================================================================
module data_distributor #(
  parameter int W = 2
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         EN,
  input  logic         AUTO,
  input  logic [1:0]   S,
  input  logic [W-1:0] DIN,
  input  logic         DIN_VLD,
  output logic         DIN_RDY,
  output logic [W-1:0] YA,
  output logic [W-1:0] YB,
  output logic [W-1:0] YC,
  output logic [W-1:0] YD,
  output logic [3:0]   VLD,
  input  logic [3:0]   RDY,
  output logic [1:0]   PTR,
`ifdef DISTRIB_CNT_EN
  output logic [15:0]  CNT,
`endif
  output logic         FRM
);

  logic [3:0][W-1:0] y_q, y_d;
  logic [3:0]        vld_q, vld_d;
  logic [1:0]        ptr_q, ptr_d;
  logic              frm_q, frm_d;
  logic [1:0]        tgt;
  logic              accept;
`ifdef DISTRIB_CNT_EN
  logic [15:0]       cnt_q, cnt_d;
`endif

  always_comb begin
    tgt     = AUTO ? ptr_q : S;
    // A full target is writable only when it is being drained this cycle
    DIN_RDY = !EN && (!vld_q[tgt] || RDY[tgt]);
    accept  = DIN_VLD && DIN_RDY;
    y_d     = y_q;
    vld_d   = vld_q & ~RDY;
    ptr_d   = ptr_q;
    frm_d   = 1'b0;
    if (accept) begin
      y_d[tgt]   = DIN;
      vld_d[tgt] = 1'b1;
      if (AUTO) begin
        ptr_d = ptr_q + 2'd1;
        frm_d = (ptr_q == 2'd3);
      end
    end
`ifdef DISTRIB_CNT_EN
    cnt_d = cnt_q + {15'd0, accept};
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      y_q   <= '0;
      vld_q <= '0;
      ptr_q <= '0;
      frm_q <= 1'b0;
`ifdef DISTRIB_CNT_EN
      cnt_q <= '0;
`endif
    end else begin
      y_q   <= y_d;
      vld_q <= vld_d;
      ptr_q <= ptr_d;
      frm_q <= frm_d;
`ifdef DISTRIB_CNT_EN
      cnt_q <= cnt_d;
`endif
    end
  end

  assign YA  = y_q[0];
  assign YB  = y_q[1];
  assign YC  = y_q[2];
  assign YD  = y_q[3];
  assign VLD = vld_q;
  assign PTR = ptr_q;
  assign FRM = frm_q;
`ifdef DISTRIB_CNT_EN
  assign CNT = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_distributor.sv
`default_nettype none
// Testbench for data_distributor: directed scenarios plus randomized traffic
// checked against a channel-level behavioural model.
module tb_data_distributor;
  localparam int W = 2;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         EN = 1'b1;
  logic         AUTO = 1'b0;
  logic [1:0]   S = 2'd0;
  logic [W-1:0] DIN = '0;
  logic         DIN_VLD = 1'b0;
  logic         DIN_RDY;
  logic [W-1:0] YA, YB, YC, YD;
  logic [3:0]   VLD;
  logic [3:0]   RDY = 4'h0;
  logic [1:0]   PTR;
  logic         FRM;
`ifdef DISTRIB_CNT_EN
  logic [15:0]  CNT;
`endif

  data_distributor #(.W(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .AUTO(AUTO), .S(S), .DIN(DIN),
    .DIN_VLD(DIN_VLD), .DIN_RDY(DIN_RDY), .YA(YA), .YB(YB), .YC(YC), .YD(YD),
    .VLD(VLD), .RDY(RDY), .PTR(PTR),
`ifdef DISTRIB_CNT_EN
    .CNT(CNT),
`endif
    .FRM(FRM)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: four 1-deep channel buffers, a frame position, a word count
  logic [W-1:0] m_y [4];
  bit           m_full [4];
  int           m_pos;
  bit           m_frm;
  int           m_cnt;

  logic [W-1:0] dut_y [4];
  assign dut_y[0] = YA;
  assign dut_y[1] = YB;
  assign dut_y[2] = YC;
  assign dut_y[3] = YD;

  function automatic int target();
    return AUTO ? m_pos : int'(S);
  endfunction

  function automatic bit model_rdy();
    int t = target();
    return (EN == 1'b0) && (!m_full[t] || RDY[t] == 1'b1);
  endfunction

  function automatic logic [3:0] model_vld();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_full[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_y[i] = '0;
      m_full[i] = 0;
    end
    m_pos = 0;
    m_frm = 0;
    m_cnt = 0;
  endtask

  task automatic drive(input bit en, input bit au, input int s, input int din,
                       input bit dv, input logic [3:0] rdy);
    EN = en; AUTO = au; S = 2'(s); DIN = W'(din); DIN_VLD = dv; RDY = rdy;
    #1;
  endtask

  // One clock: decide the transfer from current inputs, advance model, settle at negedge
  task automatic tick();
    bit acc = DIN_VLD && model_rdy();
    int t = target();
    @(posedge CLK);
    for (int i = 0; i < 4; i++) if (m_full[i] && RDY[i]) m_full[i] = 0;
    m_frm = 0;
    if (acc) begin
      m_y[t] = DIN;
      m_full[t] = 1;
      m_cnt = (m_cnt + 1) % 65536;
      if (AUTO) begin
        m_frm = (m_pos == 3);
        m_pos = (m_pos + 1) % 4;
      end
    end
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    model_reset();
    drive(1, 0, 0, 0, 0, 4'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    if (VLD !== 4'h0) begin n_bad++; $display("FAIL reset_vld got %h want 0", VLD); end
    n_cmp++;
    if (PTR !== 2'd0) begin n_bad++; $display("FAIL reset_ptr got %0d want 0", PTR); end
    n_cmp++;
    if (FRM !== 1'b0) begin n_bad++; $display("FAIL reset_frm got %b want 0", FRM); end
    n_cmp++;
    if ({YA, YB, YC, YD} !== '0) begin n_bad++; $display("FAIL reset_y got %h want 0", {YA, YB, YC, YD}); end
    n_cmp++;
  endtask

  task automatic test_manual();
    drive(0, 0, 1, 1, 1, 4'h0);
    if (DIN_RDY !== 1'b1) begin n_bad++; $display("FAIL manual_rdy got %b want 1", DIN_RDY); end
    n_cmp++;
    tick();
    drive(0, 0, 1, 1, 0, 4'h0);
    if (VLD !== 4'b0010) begin n_bad++; $display("FAIL manual_vld got %b want 0010", VLD); end
    n_cmp++;
    if (YB !== 2'b01) begin n_bad++; $display("FAIL manual_yb got %b want 01", YB); end
    n_cmp++;
  endtask

  task automatic test_backpressure();
    drive(0, 0, 1, 2, 1, 4'h0);
    if (DIN_RDY !== 1'b0) begin n_bad++; $display("FAIL bp_blocked got %b want 0", DIN_RDY); end
    n_cmp++;
    drive(0, 0, 2, 2, 0, 4'h0);
    if (DIN_RDY !== 1'b1) begin n_bad++; $display("FAIL bp_other_chan got %b want 1", DIN_RDY); end
    n_cmp++;
    drive(0, 0, 1, 2, 1, 4'h0);
    tick();
    if (VLD !== 4'b0010 || YB !== 2'b01) begin
      n_bad++; $display("FAIL bp_hold got vld=%b yb=%b want 0010/01", VLD, YB);
    end
    n_cmp++;
    drive(0, 0, 1, 2, 1, 4'b0010);
    if (DIN_RDY !== 1'b1) begin n_bad++; $display("FAIL bp_release got %b want 1", DIN_RDY); end
    n_cmp++;
    tick();
    drive(0, 0, 1, 2, 0, 4'h0);
    if (VLD !== 4'b0010 || YB !== 2'b10) begin
      n_bad++; $display("FAIL bp_refill got vld=%b yb=%b want 0010/10", VLD, YB);
    end
    n_cmp++;
  endtask

  task automatic test_auto();
    drive(0, 0, 0, 0, 0, 4'hF);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, i, 1, 4'hF);
      tick();
      if (PTR !== 2'((i + 1) % 4)) begin
        n_bad++; $display("FAIL auto_ptr%0d got %0d want %0d", i, PTR, (i + 1) % 4);
      end
      n_cmp++;
      if (FRM !== (i == 3)) begin n_bad++; $display("FAIL auto_frm%0d got %b want %b", i, FRM, i == 3); end
      n_cmp++;
    end
    drive(0, 1, 0, 0, 0, 4'hF);
    tick();
    if (FRM !== 1'b0) begin n_bad++; $display("FAIL auto_frm_end got %b want 0", FRM); end
    n_cmp++;
    if ({YA, YB, YC, YD} !== 8'b00_01_10_11) begin
      n_bad++; $display("FAIL auto_data got %b want 00011011", {YA, YB, YC, YD});
    end
    n_cmp++;
  endtask

  task automatic test_disable();
    logic [1:0] p;
    drive(0, 1, 0, 3, 1, 4'h0);
    tick();
    p = PTR;
    drive(1, 1, 0, 2, 1, 4'h0);
    if (DIN_RDY !== 1'b0) begin n_bad++; $display("FAIL dis_rdy got %b want 0", DIN_RDY); end
    n_cmp++;
    tick();
    tick();
    if (PTR !== p || PTR !== 2'(m_pos)) begin n_bad++; $display("FAIL dis_ptr got %0d want %0d", PTR, m_pos); end
    n_cmp++;
    if (VLD !== model_vld()) begin n_bad++; $display("FAIL dis_vld got %b want %b", VLD, model_vld()); end
    n_cmp++;
    drive(1, 1, 0, 2, 1, 4'hF);
    tick();
    if (VLD !== 4'h0) begin n_bad++; $display("FAIL dis_drain got %b want 0", VLD); end
    n_cmp++;
    drive(0, 1, 0, 2, 1, 4'h0);
    if (DIN_RDY !== 1'b1) begin n_bad++; $display("FAIL dis_restore got %b want 1", DIN_RDY); end
    n_cmp++;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)));
      if (DIN_RDY !== model_rdy()) begin
        n_bad++; $display("FAIL rnd_rdy c%0d got %b want %b", c, DIN_RDY, model_rdy());
      end
      n_cmp++;
      tick();
      if (VLD !== model_vld() || PTR !== 2'(m_pos) || FRM !== m_frm) begin
        n_bad++;
        $display("FAIL rnd_state c%0d got vld=%b ptr=%0d frm=%b want %b/%0d/%b",
                 c, VLD, PTR, FRM, model_vld(), m_pos, m_frm);
      end
      n_cmp++;
      for (int i = 0; i < 4; i++) begin
        if (dut_y[i] !== m_y[i]) begin
          n_bad++; $display("FAIL rnd_y%0d c%0d got %b want %b", i, c, dut_y[i], m_y[i]);
        end
        n_cmp++;
      end
`ifdef DISTRIB_CNT_EN
      if (CNT !== 16'(m_cnt)) begin n_bad++; $display("FAIL rnd_cnt c%0d got %0d want %0d", c, CNT, m_cnt); end
      n_cmp++;
`endif
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(0, 1, 0, 1, 1, 4'h0);
    tick();
    drive(0, 1, 0, 2, 1, 4'h0);
    tick();
    drive(0, 0, 2, 3, 1, 4'h0);
    tick();
    drive(0, 0, 3, 1, 1, 4'h0);
    tick();
    drive(0, 0, 3, 1, 0, 4'h0);
    if (VLD !== 4'hF || PTR !== 2'd2) begin
      n_bad++; $display("FAIL ar_setup got vld=%h ptr=%0d want F/2", VLD, PTR);
    end
    n_cmp++;
    #1;
    RST_N = 1'b0;
    #1;
    if (VLD !== 4'h0 || PTR !== 2'd0 || {YA, YB, YC, YD} !== '0) begin
      n_bad++; $display("FAIL ar_clear got vld=%h ptr=%0d y=%h want 0/0/0", VLD, PTR, {YA, YB, YC, YD});
    end
    n_cmp++;
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
  endtask

`ifdef DISTRIB_CNT_EN
  task automatic test_counter();
    do_reset();
    drive(0, 0, 0, 1, 1, 4'hF);
    for (int i = 0; i < 65535; i++) tick();
    if (CNT !== 16'hFFFF) begin n_bad++; $display("FAIL cnt_full got %h want ffff", CNT); end
    n_cmp++;
    tick();
    if (CNT !== 16'h0000) begin n_bad++; $display("FAIL cnt_wrap got %h want 0000", CNT); end
    n_cmp++;
    drive(0, 0, 0, 1, 0, 4'hF);
    for (int i = 0; i < 3; i++) tick();
    if (CNT !== 16'h0000) begin n_bad++; $display("FAIL cnt_drain got %h want 0000", CNT); end
    n_cmp++;
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_manual();
    test_backpressure();
    test_auto();
    test_disable();
    test_random();
    test_async_reset();
`ifdef DISTRIB_CNT_EN
    test_counter();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
